display_scanner: RTL and testbench

//  Downstream stage of the memory control unit while it is in its DISPLAY state.

---
 rtl/display_scanner.sv | 113 +++++++++++
 tb/tb_display_scanner.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scanner.sv
// Frame-buffer scanner: fetches each word at the control unit's ADDR and shifts it out
// MSB-first on a valid/ready pixel stream, stepping ADDR per word and signalling frame end.
module display_scanner #(
  parameter int DATA_W = 8,
  parameter int NWORDS = 339,
  parameter int RD_LAT = 2
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      start,
  input  logic [DATA_W-1:0]         rd_data,
  input  logic                      pix_ready,
  output logic                      pix_data,
  output logic                      pix_valid,
  output logic                      addr_increment,
  output logic                      clc,
  output logic                      busy,
  output logic [$clog2(NWORDS)-1:0] word_idx
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int WW = $clog2(NWORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] sreg;
  logic [BW-1:0]     bit_cnt;
  logic [LW-1:0]     lat_cnt;

  logic lat_done, last_bit, last_word;

  assign lat_done  = (lat_cnt == LW'(RD_LAT - 1));
  assign last_bit  = (bit_cnt == BW'(DATA_W - 1));
  assign last_word = (word_idx == WW'(NWORDS - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start) state_next = S_WAIT;
      S_WAIT:  if (lat_done) state_next = S_SHIFT;
      S_SHIFT: if (pix_ready && last_bit) state_next = last_word ? S_DONE : S_NEXT;
      S_NEXT:  state_next = S_WAIT;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: lat_cnt paces the read latency, sreg/bit_cnt serialise the captured word.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sreg     <= '0;
      bit_cnt  <= '0;
      lat_cnt  <= '0;
      word_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            lat_cnt  <= '0;
            word_idx <= '0;
          end
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt + LW'(1);
          if (lat_done) begin
            sreg    <= rd_data;
            bit_cnt <= '0;
          end
        end
        S_SHIFT: begin
          if (pix_ready) begin
            sreg    <= {sreg[DATA_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        S_NEXT: begin
          word_idx <= word_idx + WW'(1);
          lat_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only; no input reaches an output combinationally.
  always_comb begin
    pix_valid      = 1'b0;
    pix_data       = 1'b0;
    addr_increment = 1'b0;
    clc            = 1'b0;
    busy           = (state != S_IDLE);
    if (state == S_SHIFT) begin
      pix_valid = 1'b1;
      pix_data  = sreg[DATA_W-1];
    end
    if (state == S_NEXT) addr_increment = 1'b1;
    if (state == S_DONE) clc = 1'b1;
  end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner: small 4-word frame, RD_LAT=4 variant and default
// 339-word frame, each fed by a registered ADDR + synchronous RAM model.
module tb_display_scanner;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: NWORDS=4, RD_LAT=2
  logic       start_a = 1'b0, ready_a = 1'b1;
  logic [7:0] rd_a;
  logic       data_a, valid_a, inc_a, clc_a, busy_a;
  logic [1:0] widx_a;
  logic [7:0] mem_a [4];
  logic [1:0] addr_a;

  // Instance B: NWORDS=2, RD_LAT=4
  logic       start_b = 1'b0, ready_b = 1'b1;
  logic [7:0] rd_b;
  logic       data_b, valid_b, inc_b, clc_b, busy_b;
  logic [0:0] widx_b;
  logic [7:0] mem_b [2];
  logic       addr_b;
  logic [7:0] p1_b, p2_b;

  // Instance C: defaults
  logic       start_c = 1'b0, ready_c = 1'b1;
  logic [7:0] rd_c = 8'hC3;
  logic       data_c, valid_c, inc_c, clc_c, busy_c;
  logic [8:0] widx_c;

  display_scanner #(.DATA_W(8), .NWORDS(4), .RD_LAT(2)) dut_a (
    .CLK(CLK), .RESET(RESET), .start(start_a), .rd_data(rd_a), .pix_ready(ready_a),
    .pix_data(data_a), .pix_valid(valid_a), .addr_increment(inc_a), .clc(clc_a),
    .busy(busy_a), .word_idx(widx_a));

  display_scanner #(.DATA_W(8), .NWORDS(2), .RD_LAT(4)) dut_b (
    .CLK(CLK), .RESET(RESET), .start(start_b), .rd_data(rd_b), .pix_ready(ready_b),
    .pix_data(data_b), .pix_valid(valid_b), .addr_increment(inc_b), .clc(clc_b),
    .busy(busy_b), .word_idx(widx_b));

  display_scanner dut_c (
    .CLK(CLK), .RESET(RESET), .start(start_c), .rd_data(rd_c), .pix_ready(ready_c),
    .pix_data(data_c), .pix_valid(valid_c), .addr_increment(inc_c), .clc(clc_c),
    .busy(busy_c), .word_idx(widx_c));

  // Control-unit ADDR register clears on start (entering DISPLAY), steps on addr_increment.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr_a <= '0;
      rd_a   <= '0;
    end else begin
      if (start_a && !busy_a) addr_a <= '0;
      else if (inc_a)         addr_a <= addr_a + 2'd1;
      rd_a <= mem_a[addr_a];
    end
  end

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr_b <= '0;
      p1_b   <= '0;
      p2_b   <= '0;
      rd_b   <= '0;
    end else begin
      if (start_b && !busy_b) addr_b <= '0;
      else if (inc_b)         addr_b <= addr_b + 1'b1;
      p1_b <= mem_b[addr_b];
      p2_b <= p1_b;
      rd_b <= p2_b;
    end
  end

  task automatic run_frame_a(input bit bp, input bit noise,
                             output logic [31:0] bits, output int nbits,
                             output int n_inc, output int n_clc, output int clc_cyc,
                             output int first_v, output int stall_err, output int pulse_err,
                             output logic busy_after, output logic [1:0] widx_clc);
    logic [3:0] pat;
    logic prev_stall, prev_d, prev_inc, prev_clc;
    pat = 4'b1001;
    bits = '0; nbits = 0; n_inc = 0; n_clc = 0; clc_cyc = -1; first_v = -1;
    stall_err = 0; pulse_err = 0; busy_after = 1'bx; widx_clc = 'x;
    prev_stall = 1'b0; prev_d = 1'b0; prev_inc = 1'b0; prev_clc = 1'b0;
    ready_a = 1'b1;
    start_a = 1'b1;
    @(posedge CLK); #1;
    start_a = 1'b0;
    for (int k = 1; k < 300; k++) begin
      if (valid_a && first_v < 0) first_v = k;
      if (prev_stall && (data_a !== prev_d || valid_a !== 1'b1)) stall_err++;
      if ((inc_a && clc_a) || (inc_a && prev_inc) || (clc_a && prev_clc)) pulse_err++;
      if (inc_a) n_inc++;
      if (clc_a) begin
        n_clc++;
        if (clc_cyc < 0) begin
          clc_cyc  = k;
          widx_clc = widx_a;
        end
      end
      if (clc_cyc >= 0 && k == clc_cyc + 1) begin
        busy_after = busy_a;
        break;
      end
      ready_a = bp ? pat[k % 4] : 1'b1;
      start_a = noise && (valid_a || clc_a);
      if (valid_a && ready_a) begin
        bits = {bits[30:0], data_a};
        nbits++;
      end
      prev_stall = valid_a && !ready_a;
      prev_d     = data_a;
      prev_inc   = inc_a;
      prev_clc   = clc_a;
      @(posedge CLK); #1;
    end
    start_a = 1'b0;
    ready_a = 1'b1;
  endtask

  task automatic test_reset;
    int seen, bad;
    repeat (3) @(posedge CLK);
    #1;
    n_tests++;
    if ({valid_a, data_a, inc_a, clc_a, busy_a} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000", {valid_a, data_a, inc_a, clc_a, busy_a});
    end
    n_tests++;
    if (widx_a !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_word_idx: got %0d want 0", widx_a);
    end
    RESET = 1'b0;
    @(posedge CLK); #1;
    start_a = 1'b1;
    @(posedge CLK); #1;
    start_a = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (valid_a) seen = 1;
      else begin
        @(posedge CLK); #1;
      end
    end
    n_tests++;
    if (seen != 1) begin
      n_fail++;
      $display("FAIL reset_reach_shift: pix_valid seen=%0d want 1", seen);
    end
    repeat (2) @(posedge CLK);
    #3;
    RESET = 1'b1;
    #1;
    n_tests++;
    if ({valid_a, inc_a, clc_a, busy_a} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_midframe_async: valid,inc,clc,busy=%b want 0000",
               {valid_a, inc_a, clc_a, busy_a});
    end
    n_tests++;
    if (widx_a !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_midframe_word_idx: got %0d want 0", widx_a);
    end
    #2;
    RESET = 1'b0;
    bad = 0;
    repeat (5) begin
      @(posedge CLK); #1;
      if (busy_a !== 1'b0 || valid_a !== 1'b0 || inc_a !== 1'b0 || clc_a !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_idle_after_release: %0d non-idle cycles, want 0", bad);
    end
  endtask

  task automatic test_frame;
    logic [31:0] bits;
    int nbits, n_inc, n_clc, clc_cyc, first_v, stall_err, pulse_err;
    logic busy_after;
    logic [1:0] widx_clc;
    run_frame_a(1'b0, 1'b0, bits, nbits, n_inc, n_clc, clc_cyc, first_v, stall_err,
                pulse_err, busy_after, widx_clc);
    n_tests++;
    if (bits !== 32'hA53CFF01) begin n_fail++; $display("FAIL frame_bits: got %h want a53cff01", bits); end
    n_tests++;
    if (nbits != 32) begin n_fail++; $display("FAIL frame_nbits: got %0d want 32", nbits); end
    n_tests++;
    if (n_inc != 3) begin n_fail++; $display("FAIL frame_addr_inc: got %0d want 3", n_inc); end
    n_tests++;
    if (n_clc != 1) begin n_fail++; $display("FAIL frame_clc_count: got %0d want 1", n_clc); end
    n_tests++;
    if (clc_cyc != 44) begin n_fail++; $display("FAIL frame_clc_cycle: got %0d want 44", clc_cyc); end
    n_tests++;
    if (first_v != 3) begin n_fail++; $display("FAIL frame_first_valid: got %0d want 3", first_v); end
    n_tests++;
    if (pulse_err != 0) begin n_fail++; $display("FAIL frame_pulse_rules: got %0d violations want 0", pulse_err); end
    n_tests++;
    if (busy_after !== 1'b0) begin n_fail++; $display("FAIL frame_busy_after: got %b want 0", busy_after); end
    n_tests++;
    if (widx_clc !== 2'd3) begin n_fail++; $display("FAIL frame_word_idx_end: got %0d want 3", widx_clc); end
  endtask

  task automatic test_backpressure;
    logic [31:0] bits;
    int nbits, n_inc, n_clc, clc_cyc, first_v, stall_err, pulse_err;
    logic busy_after;
    logic [1:0] widx_clc;
    run_frame_a(1'b1, 1'b0, bits, nbits, n_inc, n_clc, clc_cyc, first_v, stall_err,
                pulse_err, busy_after, widx_clc);
    n_tests++;
    if (bits !== 32'hA53CFF01) begin n_fail++; $display("FAIL bp_bits: got %h want a53cff01", bits); end
    n_tests++;
    if (nbits != 32) begin n_fail++; $display("FAIL bp_nbits: got %0d want 32", nbits); end
    n_tests++;
    if (stall_err != 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d unstable cycles want 0", stall_err); end
    n_tests++;
    if (n_inc != 3 || n_clc != 1) begin
      n_fail++;
      $display("FAIL bp_pulses: inc=%0d clc=%0d want 3 and 1", n_inc, n_clc);
    end
  endtask

  task automatic test_latency;
    logic [15:0] bits;
    int first_v, clc_cyc;
    bits = '0; first_v = -1; clc_cyc = -1;
    start_b = 1'b1;
    @(posedge CLK); #1;
    start_b = 1'b0;
    for (int k = 1; k < 80; k++) begin
      if (valid_b && first_v < 0) first_v = k;
      if (clc_b && clc_cyc < 0) clc_cyc = k;
      if (clc_cyc >= 0) break;
      if (valid_b && ready_b) bits = {bits[14:0], data_b};
      @(posedge CLK); #1;
    end
    n_tests++;
    if (first_v != 5) begin n_fail++; $display("FAIL lat4_first_valid: got %0d want 5", first_v); end
    n_tests++;
    if (bits !== 16'h5AC1) begin n_fail++; $display("FAIL lat4_bits: got %h want 5ac1", bits); end
    n_tests++;
    if (clc_cyc != 26) begin n_fail++; $display("FAIL lat4_clc_cycle: got %0d want 26", clc_cyc); end
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] bits;
    int nbits, n_inc, n_clc, clc_cyc, first_v, stall_err, pulse_err;
    logic busy_after;
    logic [1:0] widx_clc;
    run_frame_a(1'b0, 1'b1, bits, nbits, n_inc, n_clc, clc_cyc, first_v, stall_err,
                pulse_err, busy_after, widx_clc);
    n_tests++;
    if (bits !== 32'hA53CFF01 || nbits != 32) begin
      n_fail++;
      $display("FAIL b2b_noise_bits: got %h/%0d want a53cff01/32", bits, nbits);
    end
    n_tests++;
    if (n_clc != 1) begin n_fail++; $display("FAIL b2b_noise_clc: got %0d want 1", n_clc); end
    n_tests++;
    if (n_inc != 3) begin n_fail++; $display("FAIL b2b_noise_inc: got %0d want 3", n_inc); end
    n_tests++;
    if (clc_cyc != 44) begin n_fail++; $display("FAIL b2b_noise_clc_cycle: got %0d want 44", clc_cyc); end
    n_tests++;
    if (busy_after !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after_done: got %b want 0", busy_after); end
    run_frame_a(1'b0, 1'b0, bits, nbits, n_inc, n_clc, clc_cyc, first_v, stall_err,
                pulse_err, busy_after, widx_clc);
    n_tests++;
    if (bits !== 32'hA53CFF01 || nbits != 32) begin
      n_fail++;
      $display("FAIL b2b_second_bits: got %h/%0d want a53cff01/32", bits, nbits);
    end
    n_tests++;
    if (n_clc != 1 || clc_cyc != 44) begin
      n_fail++;
      $display("FAIL b2b_second_clc: count=%0d cycle=%0d want 1 at 44", n_clc, clc_cyc);
    end
  endtask

  task automatic test_default_frame;
    int n_inc, n_clc, clc_cyc, overlap;
    logic [8:0] widx_end;
    n_inc = 0; n_clc = 0; clc_cyc = -1; overlap = 0; widx_end = 'x;
    start_c = 1'b1;
    @(posedge CLK); #1;
    start_c = 1'b0;
    for (int k = 1; k < 5000; k++) begin
      if (inc_c && clc_c) overlap++;
      if (inc_c) n_inc++;
      if (clc_c) begin
        n_clc++;
        clc_cyc  = k;
        widx_end = widx_c;
        break;
      end
      @(posedge CLK); #1;
    end
    n_tests++;
    if (n_inc != 338) begin n_fail++; $display("FAIL dflt_addr_inc: got %0d want 338", n_inc); end
    n_tests++;
    if (n_clc != 1 || clc_cyc != 3729) begin
      n_fail++;
      $display("FAIL dflt_clc: count=%0d cycle=%0d want 1 at 3729", n_clc, clc_cyc);
    end
    n_tests++;
    if (widx_end !== 9'd338) begin n_fail++; $display("FAIL dflt_word_idx: got %0d want 338", widx_end); end
    n_tests++;
    if (overlap != 0) begin n_fail++; $display("FAIL dflt_overlap: got %0d want 0", overlap); end
    @(posedge CLK); #1;
  endtask

  initial begin
    mem_a[0] = 8'hA5; mem_a[1] = 8'h3C; mem_a[2] = 8'hFF; mem_a[3] = 8'h01;
    mem_b[0] = 8'h5A; mem_b[1] = 8'hC1;
    test_reset();
    test_frame();
    test_backpressure();
    test_latency();
    test_back_to_back();
    test_default_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
